// File: rtl/pwm_channel_serializer.sv
// PWM/brightness word serialiser for a constant-current LED driver chip.
// Generates shift clock, data and latch under a start/busy/done handshake.
module pwm_channel_serializer #(
    parameter int CHANNELS    = 16,
    parameter int PWM_BITS    = 8,
    parameter int BRIGHT_BITS = 8,
    parameter int CLK_DIV     = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         mode,
    input  logic [PWM_BITS-1:0]          pwm_time,
    input  logic [CHANNELS*PWM_BITS-1:0] component_values,
    input  logic                         brightness_wr,
    input  logic [BRIGHT_BITS-1:0]       brightness_in,
    output logic                         busy,
    output logic                         done,
    output logic                         serial_data_out,
    output logic                         serial_clk_out,
    output logic                         latch_out
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int IW = $clog2(CHANNELS);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(CHANNELS - 1);

    if (CHANNELS < 2) begin : g_chk_ch
        $error("CHANNELS must be >= 2");
    end
    if (BRIGHT_BITS > CHANNELS) begin : g_chk_br
        $error("BRIGHT_BITS must be <= CHANNELS");
    end
    if (CLK_DIV < 1) begin : g_chk_div
        $error("CLK_DIV must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CHANNELS-1:0]    shreg, cmp, word_nxt;
    logic [DW-1:0]          div_cnt;
    logic [IW-1:0]          bit_idx;
    logic                   phase;
    logic [BRIGHT_BITS-1:0] bright_reg;
    logic                   div_end, last_bit;

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp[i] = pwm_time < component_values[PWM_BITS*i +: PWM_BITS];
        end
        word_nxt = mode ? CHANNELS'(bright_reg) : cmp;
    end

    assign div_end  = div_cnt == DIV_MAX;
    assign last_bit = bit_idx == '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = SHIFT;
            SHIFT: if (div_end && phase && last_bit) state_nxt = LATCH;
            LATCH: if (div_end) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // phase: 0 = low half of the serial clock, 1 = high half
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    shreg   <= word_nxt;
                    bit_idx <= IDX_TOP;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
                SHIFT: if (div_end) begin
                    div_cnt <= '0;
                    phase   <= ~phase;
                    if (phase && !last_bit) begin
                        bit_idx <= bit_idx - 1'b1;
                        shreg   <= shreg << 1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                LATCH: div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                default: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          bright_reg <= '1;
        else if (brightness_wr) bright_reg <= brightness_in;
    end

    assign busy            = state != IDLE;
    assign done            = state == DONE;
    assign serial_clk_out  = (state == SHIFT) && phase;
    assign serial_data_out = (state == SHIFT) && shreg[CHANNELS-1];
    assign latch_out       = state == LATCH;

endmodule

// File: tb/tb_pwm_channel_serializer.sv
// Bench for pwm_channel_serializer: default and CLK_DIV=3 instances
// checked cycle by cycle against a waveform model of each frame.
module tb_pwm_channel_serializer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start1 = 1'b0, start3 = 1'b0;
    logic         mode = 1'b0;
    logic [7:0]   pwm_time = '0;
    logic [127:0] comps = '0;
    logic         brightness_wr = 1'b0;
    logic [7:0]   brightness_in = '0;
    logic         busy1, done1, sd1, sc1, la1;
    logic         busy3, done3, sd3, sc3, la3;

    int errors = 0;
    int checks = 0;
    logic [7:0] bright_m = 8'hFF;

    always #5 clk = ~clk;

    pwm_channel_serializer dut (
        .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode),
        .pwm_time(pwm_time), .component_values(comps),
        .brightness_wr(brightness_wr), .brightness_in(brightness_in),
        .busy(busy1), .done(done1), .serial_data_out(sd1),
        .serial_clk_out(sc1), .latch_out(la1)
    );

    pwm_channel_serializer #(.CLK_DIV(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .mode(mode),
        .pwm_time(pwm_time), .component_values(comps),
        .brightness_wr(brightness_wr), .brightness_in(brightness_in),
        .busy(busy3), .done(done3), .serial_data_out(sd3),
        .serial_clk_out(sc3), .latch_out(la3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input bit m,
            input logic [7:0] t, input logic [127:0] cv, input logic [7:0] b);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = int'(t) < int'(cv[8*i +: 8]);
        if (m) w = {8'h00, b};
        return w;
    endfunction

    // {busy, done, data, sclk, latch}
    function automatic logic [4:0] outs(input bit on3);
        return on3 ? {busy3, done3, sd3, sc3, la3}
                   : {busy1, done1, sd1, sc1, la1};
    endfunction

    // Expected outputs c cycles after the cycle in which start was sampled
    function automatic logic [4:0] expect_at(input int c, input int d,
                                             input logic [15:0] w);
        int total, done_c, k;
        total  = 32 * d;
        done_c = 1 + total + d;
        if (c >= 1 && c <= total) begin
            k = (c - 1) / (2 * d);
            return {1'b1, 1'b0, w[15-k], ((c - 1) % (2 * d)) >= d, 1'b0};
        end
        if (c > total && c < done_c) return 5'b10001;
        if (c == done_c) return 5'b11000;
        return 5'b00000;
    endfunction

    task automatic set_start(input bit on3, input logic v);
        if (on3) start3 = v;
        else     start1 = v;
    endtask

    task automatic frame(input bit on3, input bit m, input logic [7:0] t,
                         input logic [127:0] cv, input bit poke);
        int d, done_c;
        logic [15:0] w;
        d = on3 ? 3 : 1;
        done_c = 1 + 32 * d + d;
        w = model_word(m, t, cv, bright_m);
        @(negedge clk);
        mode = m; pwm_time = t; comps = cv;
        set_start(on3, 1'b1);
        @(negedge clk);
        set_start(on3, 1'b0);
        for (int c = 1; c <= done_c + 1; c++) begin
            check($sformatf("frame d=%0d w=%04h c=%0d", d, w, c),
                  32'(outs(on3)), 32'(expect_at(c, d, w)));
            brightness_wr = 1'b0;
            set_start(on3, 1'b0);
            if (poke && c == 5) begin
                brightness_wr = 1'b1;
                brightness_in = 8'h3C;
                mode = ~m;
                pwm_time = 8'($urandom);
                comps = {$urandom, $urandom, $urandom, $urandom};
                set_start(on3, 1'b1);
            end
            if (poke && c == done_c) set_start(on3, 1'b1);
            @(negedge clk);
        end
        brightness_wr = 1'b0;
        set_start(on3, 1'b0);
        if (poke) bright_m = 8'h3C;
        check("idle after frame", 32'(outs(on3)), 32'd0);
    endtask

    task automatic write_bright(input logic [7:0] v);
        @(negedge clk);
        brightness_wr = 1'b1;
        brightness_in = v;
        @(negedge clk);
        brightness_wr = 1'b0;
        bright_m = v;
    endtask

    initial begin
        logic [127:0] cv;
        logic [15:0]  w;

        repeat (2) @(negedge clk);
        check("reset outs d1", 32'(outs(1'b0)), 32'd0);
        check("reset outs d3", 32'(outs(1'b1)), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", 32'(outs(1'b0)), 32'd0);

        // reset brightness is all ones
        frame(1'b0, 1'b1, 8'h00, '0, 1'b0);

        for (int i = 0; i < 16; i++) cv[8*i +: 8] = 8'(i * 16);
        frame(1'b0, 1'b0, 8'h40, cv, 1'b0);

        cv = {$urandom, $urandom, $urandom, $urandom};
        cv[15:0] = 16'h00FF;
        frame(1'b0, 1'b0, 8'hFF, cv, 1'b0);
        frame(1'b0, 1'b0, 8'h00, cv, 1'b0);

        // mid-frame write and ignored starts, then the new value is used
        frame(1'b0, 1'b0, 8'h40, {$urandom, $urandom, $urandom, $urandom},
              1'b1);
        frame(1'b0, 1'b1, 8'h00, '0, 1'b0);

        frame(1'b1, 1'b1, 8'h00, '0, 1'b0);
        frame(1'b1, 1'b0, 8'h80, {$urandom, $urandom, $urandom, $urandom},
              1'b0);

        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 1) write_bright(8'($urandom));
            frame(n % 3 == 2, 1'($urandom), 8'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        // reset while word bit 7 is on the line
        cv = {$urandom, $urandom, $urandom, $urandom};
        w = model_word(1'b0, 8'h55, cv, bright_m);
        @(negedge clk);
        mode = 1'b0; pwm_time = 8'h55; comps = cv; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("pre-abort c=%0d", c), 32'(outs(1'b0)),
                  32'(expect_at(c, 1, w)));
            if (c < 17) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("abort outs", 32'(outs(1'b0)), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bright_m = 8'hFF;
        for (int c = 0; c < 40; c++) begin
            if (outs(1'b0) != 5'd0 || c == 39)
                check($sformatf("no latch after abort c=%0d", c),
                      32'(outs(1'b0)), 32'd0);
            @(negedge clk);
        end
        frame(1'b0, 1'b0, 8'h55, cv, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_channel_serializer.md
Name: pwm_channel_serializer

Overview:
Parametrised successor to the per-colour PWM driver for the LED panel. It compares CHANNELS component values against the shared PWM time base, or selects the host-written brightness word. It then serialises the result MSB-first to an external constant-current LED driver chip. Serial clock, latch and completion are generated internally under a start/busy/done handshake, so the panel controller only issues one start per frame slice.

Parameters:
CHANNELS, 16, number of LED outputs driven (serial word width); must be >= 2.
PWM_BITS, 8, width of each component value and of pwm_time.
BRIGHT_BITS, 8, width of brightness register; must be <= CHANNELS (elaboration error otherwise).
CLK_DIV, 1, clk cycles per serial-clock half period; must be >= 1.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to send a word; sampled only in IDLE.
mode  input  1  sampled with start: 0 = PWM comparison word, 1 = brightness word.
pwm_time  input  PWM_BITS  current PWM time slot, sampled with start.
component_values  input  CHANNELS*PWM_BITS  channel i at bits [PWM_BITS*i +: PWM_BITS], sampled with start.
brightness_wr  input  1  write strobe for brightness register.
brightness_in  input  BRIGHT_BITS  brightness value written on brightness_wr.
busy  output  1  high while a transfer is in progress (state != IDLE).
done  output  1  one-cycle pulse at end of transfer.
serial_data_out  output  1  serial data to driver chip.
serial_clk_out  output  1  serial shift clock to driver chip.
latch_out  output  1  latch strobe to driver chip.

Behaviour:
- Reset (async, any state): state IDLE. busy, done, serial_data_out, serial_clk_out and latch_out all 0. Shift word 0, counters 0. brightness_reg = all ones.
- brightness_wr: brightness_reg <= brightness_in on the next edge, accepted in any state. It never alters a word already captured. If brightness_wr and start (mode=1) occur in the same cycle, the frame uses the old brightness_reg value.
- Word formation at start:
  - mode=0: word[i] = (pwm_time < component_values channel i), unsigned strict less-than. A value of 0 is always off. A value of all-ones is on except when pwm_time is all-ones.
  - mode=1: word = brightness_reg zero-extended to CHANNELS bits.
- States: IDLE -> SHIFT -> LATCH -> DONE -> IDLE.
- IDLE: start=1 captures word and sets bit index = CHANNELS-1. Next cycle: SHIFT, with serial_data_out = word[CHANNELS-1] and serial_clk_out = 0. start=0 keeps IDLE.
- SHIFT, per bit:
  - serial_clk_out is 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - serial_data_out is stable for the whole 2*CLK_DIV period and changes only in the cycle serial_clk_out returns to 0.
  - Bits are sent in order word[CHANNELS-1] down to word[0].
- After the high phase of word[0]: LATCH. serial_clk_out = 0, serial_data_out = 0, latch_out = 1 for CLK_DIV cycles.
- DONE: latch_out = 0, done = 1 for exactly one cycle, busy still 1. Then IDLE, with busy = 0.
- Timing: start sampled at cycle 0 -> done high at cycle 1 + 2*CHANNELS*CLK_DIV + CLK_DIV.
  - Defaults: done at cycle 34; busy high cycles 1..34.
- start while busy (including the DONE cycle): ignored, no queuing.
- Divider counter: width clog2(CLK_DIV)+1. Bit index: width clog2(CHANNELS). No wrap beyond the defined states.
- Reset mid-transfer: the frame is aborted with no latch pulse. The next start sends a complete fresh word.

Test Plan:
- Reset then start mode=1 (defaults) -> serial bits 0000_0000_1111_1111 (brightness 0xFF), latch_out high cycle 33, done cycle 34.
- Channel i = i*16, pwm_time=0x40, mode=0 -> word 0xFFE0, i.e. 11 ones then 5 zeros; data sampled on each serial_clk_out rising edge matches.
- pwm_time=0xFF with ch0=0xFF, ch1=0x00 -> word bits 0,1 = 0. pwm_time=0x00 with the same values -> bit0=1, bit1=0.
- brightness_wr 0x3C and a second start during a busy frame -> current frame unchanged, second start ignored. Next start mode=1 -> word 0x003C.
- CLK_DIV=3 -> serial_clk_out alternates 3 low / 3 high cycles, latch_out high 3 cycles, done at cycle 100.
- reset_n low while bit 7 is shifting -> all outputs 0 immediately, no latch. After release, start -> full 16-bit frame, done 34 cycles later.
